pe_loader: RTL and testbench

- Clocked sequencer directly upstream of the 1-D row-convolution PE; drives its filter, ifmap, psum_in and start inputs and consumes its done.
- Host stages one job (filter row, ifmap row, per-output bias) into local buffers, then pulses go.
- Block streams filter and ifmap words with addresses, issues start, feeds psum_in words in PE consumption order, and waits for done.

---
 rtl/pe_loader_pkg.sv | 26 ++
 rtl/pe_loader_stream.sv | 55 +++++
 rtl/pe_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_pe_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_loader_pkg.sv
// pe_loader_pkg: shared state encoding, staging-select codes and sizing helper
// for the pe_loader sequencer and its word streamer.
package pe_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_I,
        START,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        SEL_FILTER = 2'd0,
        SEL_IFMAP  = 2'd1,
        SEL_BIAS   = 2'd2,
        SEL_RSVD   = 2'd3
    } wr_sel_t;

    // Number of valid output positions of a 1-D convolution with no padding.
    function automatic int unsigned num_out(input int unsigned depth_i,
                                            input int unsigned depth_f);
        return depth_i - depth_f + 1;
    endfunction

endpackage

// File: rtl/pe_loader_stream.sv
// pe_loader_stream: sends DEPTH buffered words over a valid/ready channel,
// one per accepted transfer, with the word index presented as the address.
// Data/addr are driven from registered state only, so they hold while stalled.
module pe_loader_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned ADDR  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] words_i,
    input  logic                        ready_i,
    output logic                        valid_o,
    output logic [WIDTH-1:0]            data_o,
    output logic [ADDR-1:0]             addr_o,
    output logic                        last_o
);

    localparam logic [ADDR-1:0] LAST_IDX = ADDR'(DEPTH - 1);

    logic            active_q;
    logic [ADDR-1:0] idx_q;

    // Index/active tracking: start reloads index 0, each transfer advances it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            idx_q    <= '0;
        end else if (active_q && ready_i) begin
            if (idx_q == LAST_IDX) begin
                active_q <= 1'b0;
                idx_q    <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Word select for the current index; outputs read zero while idle.
    always_comb begin
        data_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (active_q && (idx_q == ADDR'(k))) data_o = words_i[k];
        end
    end

    assign valid_o = active_q;
    assign addr_o  = active_q ? idx_q : '0;
    assign last_o  = active_q && ready_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/pe_loader.sv
// pe_loader: stages one row-convolution job (filter, ifmap, bias) from the host
// and sequences it into the PE: filter words, ifmap words, start token, then
// the psum_in stream while waiting for the PE's done token.
// Optional: define PE_LOADER_FILTER_SKIP_EN to skip LOAD_F when the filter
// buffer has not been written since the last filter load (or reset).
module pe_loader
    import pe_loader_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH_F = 3,
    parameter int unsigned ADDR_F  = 2,
    parameter int unsigned DEPTH_I = 5,
    parameter int unsigned ADDR_I  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr_en,
    input  logic [1:0]        cfg_wr_sel,
    input  logic [2:0]        cfg_wr_addr,
    input  logic [WIDTH-1:0]  cfg_wr_data,
    input  logic              go,
    output logic              busy,
    output logic              job_done,
    output logic              seq_err,
    output logic              f_valid,
    input  logic              f_ready,
    output logic [WIDTH-1:0]  f_data,
    output logic [ADDR_F-1:0] f_addr,
    output logic              i_valid,
    input  logic              i_ready,
    output logic [WIDTH-1:0]  i_data,
    output logic [ADDR_I-1:0] i_addr,
    output logic              p_valid,
    input  logic              p_ready,
    output logic [WIDTH-1:0]  p_data,
    output logic              start_valid,
    input  logic              start_ready,
    output logic [WIDTH-1:0]  start_data,
    input  logic              done_valid,
    output logic              done_ready
);

    localparam int unsigned NUM_OUT = num_out(DEPTH_I, DEPTH_F);
    localparam int unsigned OUT_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned TAP_W   = $clog2(DEPTH_F + 1);
    localparam logic [OUT_W-1:0] LAST_OUT = OUT_W'(NUM_OUT - 1);
    localparam logic [TAP_W-1:0] BIAS_TAP = TAP_W'(DEPTH_F);

    logic [DEPTH_F-1:0][WIDTH-1:0] filter_q;
    logic [DEPTH_I-1:0][WIDTH-1:0] ifmap_q;
    logic [NUM_OUT-1:0][WIDTH-1:0] bias_q;

    state_t            state_q;
    logic              busy_q, job_done_q, seq_err_q;
    logic              start_valid_q, done_ready_q;
    logic              p_valid_q, p_sent_q, done_seen_q;
    logic [TAP_W-1:0]  tap_q;
    logic [OUT_W-1:0]  out_q;
`ifdef PE_LOADER_FILTER_SKIP_EN
    logic              filter_dirty_q;
`endif

    logic [DEPTH_F-1:0] f_we;
    logic [DEPTH_I-1:0] i_we;
    logic [NUM_OUT-1:0] b_we;
    logic go_acc, skip_f, f_start, i_start, f_last, i_last;
    logic p_xfer, p_bias, p_last, d_xfer, psum_fin, done_fin;

    // Staging write decode: IDLE only, out-of-range addresses match no entry.
    always_comb begin
        f_we = '0;
        i_we = '0;
        b_we = '0;
        if (cfg_wr_en && (state_q == IDLE)) begin
            for (int unsigned k = 0; k < DEPTH_F; k++)
                if ((wr_sel_t'(cfg_wr_sel) == SEL_FILTER) && (cfg_wr_addr == 3'(k))) f_we[k] = 1'b1;
            for (int unsigned k = 0; k < DEPTH_I; k++)
                if ((wr_sel_t'(cfg_wr_sel) == SEL_IFMAP) && (cfg_wr_addr == 3'(k))) i_we[k] = 1'b1;
            for (int unsigned k = 0; k < NUM_OUT; k++)
                if ((wr_sel_t'(cfg_wr_sel) == SEL_BIAS) && (cfg_wr_addr == 3'(k))) b_we[k] = 1'b1;
        end
    end

    // Job buffers written by the host while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filter_q <= '0;
            ifmap_q  <= '0;
            bias_q   <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH_F; k++) if (f_we[k]) filter_q[k] <= cfg_wr_data;
            for (int unsigned k = 0; k < DEPTH_I; k++) if (i_we[k]) ifmap_q[k]  <= cfg_wr_data;
            for (int unsigned k = 0; k < NUM_OUT; k++) if (b_we[k]) bias_q[k]   <= cfg_wr_data;
        end
    end

    assign go_acc = go && (state_q == IDLE);
`ifdef PE_LOADER_FILTER_SKIP_EN
    // A filter write coinciding with go lands first, so it also forces a reload.
    assign skip_f = !(filter_dirty_q || (|f_we));
`else
    assign skip_f = 1'b0;
`endif
    assign f_start = go_acc && !skip_f;
    assign i_start = (go_acc && skip_f) || f_last;

    assign p_xfer   = p_valid_q && p_ready;
    assign p_bias   = (tap_q == BIAS_TAP);
    assign p_last   = p_xfer && p_bias && (out_q == LAST_OUT);
    assign d_xfer   = done_ready_q && done_valid;
    assign psum_fin = p_sent_q || p_last;
    assign done_fin = done_seen_q || d_xfer;

    // Psum word for the current position: DEPTH_F zeros then the group bias.
    always_comb begin
        p_data = '0;
        if (p_valid_q && p_bias) begin
            for (int unsigned k = 0; k < NUM_OUT; k++)
                if (out_q == OUT_W'(k)) p_data = bias_q[k];
        end
    end

    pe_loader_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH_F), .ADDR(ADDR_F)) u_f_stream (
        .clk     (clk),
        .rst     (rst),
        .start_i (f_start),
        .words_i (filter_q),
        .ready_i (f_ready),
        .valid_o (f_valid),
        .data_o  (f_data),
        .addr_o  (f_addr),
        .last_o  (f_last)
    );

    pe_loader_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH_I), .ADDR(ADDR_I)) u_i_stream (
        .clk     (clk),
        .rst     (rst),
        .start_i (i_start),
        .words_i (ifmap_q),
        .ready_i (i_ready),
        .valid_o (i_valid),
        .data_o  (i_data),
        .addr_o  (i_addr),
        .last_o  (i_last)
    );

    // Job sequencer with registered status/handshake outputs and psum counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            job_done_q    <= 1'b0;
            seq_err_q     <= 1'b0;
            start_valid_q <= 1'b0;
            done_ready_q  <= 1'b0;
            p_valid_q     <= 1'b0;
            p_sent_q      <= 1'b0;
            done_seen_q   <= 1'b0;
            tap_q         <= '0;
            out_q         <= '0;
`ifdef PE_LOADER_FILTER_SKIP_EN
            filter_dirty_q <= 1'b1;
`endif
        end else begin
            job_done_q <= 1'b0;
`ifdef PE_LOADER_FILTER_SKIP_EN
            if (|f_we) filter_dirty_q <= 1'b1;
`endif
            case (state_q)
                IDLE: begin
                    if (go_acc) begin
                        busy_q    <= 1'b1;
                        seq_err_q <= 1'b0;
                        state_q   <= skip_f ? LOAD_I : LOAD_F;
                    end
                end
                LOAD_F: begin
                    if (f_last) begin
                        state_q <= LOAD_I;
`ifdef PE_LOADER_FILTER_SKIP_EN
                        filter_dirty_q <= 1'b0;
`endif
                    end
                end
                LOAD_I: begin
                    if (i_last) begin
                        state_q       <= START;
                        start_valid_q <= 1'b1;
                    end
                end
                START: begin
                    if (start_ready) begin
                        start_valid_q <= 1'b0;
                        done_ready_q  <= 1'b1;
                        p_valid_q     <= 1'b1;
                        p_sent_q      <= 1'b0;
                        done_seen_q   <= 1'b0;
                        tap_q         <= '0;
                        out_q         <= '0;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    if (p_xfer) begin
                        if (p_bias) begin
                            tap_q <= '0;
                            if (out_q == LAST_OUT) begin
                                out_q     <= '0;
                                p_valid_q <= 1'b0;
                                p_sent_q  <= 1'b1;
                            end else begin
                                out_q <= out_q + 1'b1;
                            end
                        end else begin
                            tap_q <= tap_q + 1'b1;
                        end
                    end
                    if (d_xfer) begin
                        done_ready_q <= 1'b0;
                        done_seen_q  <= 1'b1;
                        if (!psum_fin) seq_err_q <= 1'b1;
                    end
                    // Done and stream end may land in either order or together.
                    if (psum_fin && done_fin) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        job_done_q   <= 1'b1;
                        done_ready_q <= 1'b0;
                        p_sent_q     <= 1'b0;
                        done_seen_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign job_done    = job_done_q;
    assign seq_err     = seq_err_q;
    assign start_valid = start_valid_q;
    assign start_data  = '0;
    assign done_ready  = done_ready_q;
    assign p_valid     = p_valid_q;

endmodule

// File: tb/tb_pe_loader.sv
// tb_pe_loader: directed self-checking bench for pe_loader.
module tb_pe_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_wr_en;
    logic [1:0] cfg_wr_sel;
    logic [2:0] cfg_wr_addr;
    logic [7:0] cfg_wr_data;
    logic       go;
    logic       busy, job_done, seq_err;
    logic       f_valid, f_ready;
    logic [7:0] f_data;
    logic [1:0] f_addr;
    logic       i_valid, i_ready;
    logic [7:0] i_data;
    logic [2:0] i_addr;
    logic       p_valid, p_ready;
    logic [7:0] p_data;
    logic       start_valid, start_ready;
    logic [7:0] start_data;
    logic       done_valid, done_ready;

    always #5 clk = ~clk;

    pe_loader #(.WIDTH(8), .DEPTH_F(3), .ADDR_F(2), .DEPTH_I(5), .ADDR_I(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .go(go), .busy(busy), .job_done(job_done), .seq_err(seq_err),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data), .f_addr(f_addr),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_addr(i_addr),
        .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
        .start_valid(start_valid), .start_ready(start_ready), .start_data(start_data),
        .done_valid(done_valid), .done_ready(done_ready)
    );

    int checks = 0;
    int passed = 0;

    // Observations of the most recent job, cycle 0 = cycle go was driven.
    logic [7:0] obs_fd[$], obs_id[$], obs_p[$];
    int         obs_fa[$], obs_fc[$], obs_ia[$], obs_ic[$];
    int         start_cyc, jd_cyc, jd_cnt;
    logic       busy_c1, seq_err_c1, busy_at_jd, stall_bad, timed_out;

    task automatic cfg_write(input logic [1:0] sel, input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        cfg_wr_en = 1'b1; cfg_wr_sel = sel; cfg_wr_addr = addr; cfg_wr_data = data;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic stage(input logic [2:0][7:0] f, input logic [4:0][7:0] im, input logic [2:0][7:0] b);
        for (int k = 0; k < 3; k++) cfg_write(2'd0, 3'(k), f[k]);
        for (int k = 0; k < 5; k++) cfg_write(2'd1, 3'(k), im[k]);
        for (int k = 0; k < 3; k++) cfg_write(2'd2, 3'(k), b[k]);
    endtask

    // Drives one go and plays the PE side until job_done (bounded).
    task automatic run_job(input bit p_toggle, input int done_at, input bit inject,
                           input bit go_wr, input logic [1:0] gsel, input logic [2:0] gaddr,
                           input logic [7:0] gdata);
        int   cyc;
        bit   done_given, prev_stall;
        logic [7:0] prev_p;
        obs_fd.delete(); obs_id.delete(); obs_p.delete();
        obs_fa.delete(); obs_fc.delete(); obs_ia.delete(); obs_ic.delete();
        start_cyc = -1; jd_cyc = -1; jd_cnt = 0;
        busy_c1 = 1'b0; seq_err_c1 = 1'b1; busy_at_jd = 1'b1; stall_bad = 1'b0; timed_out = 1'b0;
        f_ready = 1'b1; i_ready = 1'b1; start_ready = 1'b1; p_ready = 1'b0; done_valid = 1'b0;
        @(negedge clk);
        go = 1'b1;
        if (go_wr) begin
            cfg_wr_en = 1'b1; cfg_wr_sel = gsel; cfg_wr_addr = gaddr; cfg_wr_data = gdata;
        end
        cyc = 0; done_given = 1'b0; prev_stall = 1'b0; prev_p = '0;
        forever begin
            @(negedge clk);
            cyc++;
            go = 1'b0; cfg_wr_en = 1'b0;
            if (cyc == 1) begin busy_c1 = busy; seq_err_c1 = seq_err; end
            if (f_valid) begin obs_fa.push_back(int'(f_addr)); obs_fd.push_back(f_data); obs_fc.push_back(cyc); end
            if (i_valid) begin obs_ia.push_back(int'(i_addr)); obs_id.push_back(i_data); obs_ic.push_back(cyc); end
            if (start_valid && start_cyc < 0) start_cyc = cyc;
            if (job_done) begin
                jd_cnt++;
                if (jd_cyc < 0) begin jd_cyc = cyc; busy_at_jd = busy; end
            end
            p_ready = p_toggle ? ((cyc % 2) == 1) : 1'b1;
            if (p_valid) begin
                if (prev_stall && (p_data !== prev_p)) stall_bad = 1'b1;
                if (p_ready) obs_p.push_back(p_data);
                prev_stall = !p_ready;
                prev_p     = p_data;
            end else begin
                prev_stall = 1'b0;
            end
            done_valid = !done_given && (obs_p.size() >= done_at);
            if (done_valid && done_ready) done_given = 1'b1;
            if (inject) begin
                case (cyc)
                    2:  begin cfg_wr_en = 1'b1; cfg_wr_sel = 2'd0; cfg_wr_addr = 3'd0; cfg_wr_data = 8'hFF; end
                    5:  begin cfg_wr_en = 1'b1; cfg_wr_sel = 2'd1; cfg_wr_addr = 3'd1; cfg_wr_data = 8'hEE; end
                    7:  go = 1'b1;
                    12: begin cfg_wr_en = 1'b1; cfg_wr_sel = 2'd2; cfg_wr_addr = 3'd0; cfg_wr_data = 8'hDD; end
                    15: go = 1'b1;
                    default: ;
                endcase
            end
            if (jd_cyc >= 0 && cyc >= jd_cyc + 2) break;
            if (cyc >= 300) begin timed_out = 1'b1; break; end
        end
        p_ready = 1'b0; done_valid = 1'b0; go = 1'b0; cfg_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0]  ctl;
        logic [36:0] dz;
        #1;
        ctl = {busy, job_done, seq_err, f_valid, i_valid, p_valid, start_valid, done_ready};
        dz  = {f_data, f_addr, i_data, i_addr, p_data, start_data};
        checks++; if (ctl !== '0) $display("FAIL reset_ctl: got %b expected 00000000", ctl); else passed++;
        checks++; if (dz !== '0) $display("FAIL reset_data: got %h expected 0", dz); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_full_job();
        stage({8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, '0);
        run_job(1'b0, 12, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        checks++; if (timed_out !== 1'b0) $display("FAIL full_timeout: got %b expected 0", timed_out); else passed++;
        checks++; if (busy_c1 !== 1'b1) $display("FAIL full_busy_c1: got %b expected 1", busy_c1); else passed++;
        checks++; if (obs_fa.size() !== 3) $display("FAIL full_f_count: got %0d expected 3", obs_fa.size()); else passed++;
        for (int k = 0; k < obs_fa.size() && k < 3; k++) begin
            checks++;
            if (obs_fa[k] !== k || obs_fc[k] !== k + 1 || obs_fd[k] !== 8'(k + 1))
                $display("FAIL full_f_word%0d: got addr %0d cyc %0d data %0d expected %0d %0d %0d",
                         k, obs_fa[k], obs_fc[k], obs_fd[k], k, k + 1, k + 1);
            else passed++;
        end
        checks++; if (obs_ia.size() !== 5) $display("FAIL full_i_count: got %0d expected 5", obs_ia.size()); else passed++;
        for (int k = 0; k < obs_ia.size() && k < 5; k++) begin
            checks++;
            if (obs_ia[k] !== k || obs_ic[k] !== k + 4 || obs_id[k] !== 8'(k + 1))
                $display("FAIL full_i_word%0d: got addr %0d cyc %0d data %0d expected %0d %0d %0d",
                         k, obs_ia[k], obs_ic[k], obs_id[k], k, k + 4, k + 1);
            else passed++;
        end
        checks++; if (start_cyc !== 9) $display("FAIL full_start_cyc: got %0d expected 9", start_cyc); else passed++;
        checks++; if (obs_p.size() !== 12) $display("FAIL full_p_count: got %0d expected 12", obs_p.size()); else passed++;
        for (int k = 0; k < obs_p.size() && k < 12; k++) begin
            checks++; if (obs_p[k] !== 8'd0) $display("FAIL full_p%0d: got %0d expected 0", k, obs_p[k]); else passed++;
        end
        checks++; if (jd_cnt !== 1) $display("FAIL full_jd_cnt: got %0d expected 1", jd_cnt); else passed++;
        checks++; if (jd_cyc !== 22) $display("FAIL full_jd_cyc: got %0d expected 22", jd_cyc); else passed++;
        checks++; if (busy_at_jd !== 1'b0) $display("FAIL full_busy_at_jd: got %b expected 0", busy_at_jd); else passed++;
        checks++; if (seq_err !== 1'b0) $display("FAIL full_seq_err: got %b expected 0", seq_err); else passed++;
    endtask

    task automatic test_psum_stall();
        logic [2:0][7:0] b;
        logic [7:0]      e;
        b = {8'd7, 8'd6, 8'd5};
        // bias[2] is staged as 0 and rewritten to 7 in the same cycle as go.
        stage({8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd0, 8'd6, 8'd5});
        run_job(1'b1, 12, 1'b0, 1'b1, 2'd2, 3'd2, 8'd7);
        checks++; if (timed_out !== 1'b0) $display("FAIL stall_timeout: got %b expected 0", timed_out); else passed++;
        checks++; if (obs_p.size() !== 12) $display("FAIL stall_p_count: got %0d expected 12", obs_p.size()); else passed++;
        for (int k = 0; k < obs_p.size() && k < 12; k++) begin
            e = ((k % 4) == 3) ? b[k / 4] : 8'd0;
            checks++; if (obs_p[k] !== e) $display("FAIL stall_p%0d: got %0d expected %0d", k, obs_p[k], e); else passed++;
        end
        checks++; if (stall_bad !== 1'b0) $display("FAIL stall_hold: got %b expected 0", stall_bad); else passed++;
        checks++; if (jd_cyc !== 34) $display("FAIL stall_jd_cyc: got %0d expected 34", jd_cyc); else passed++;
        checks++; if (jd_cnt !== 1) $display("FAIL stall_jd_cnt: got %0d expected 1", jd_cnt); else passed++;
    endtask

    task automatic test_early_done();
        stage({8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd8, 8'd7});
        run_job(1'b0, 4, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        checks++; if (timed_out !== 1'b0) $display("FAIL early_timeout: got %b expected 0", timed_out); else passed++;
        checks++; if (seq_err !== 1'b1) $display("FAIL early_seq_err: got %b expected 1", seq_err); else passed++;
        checks++; if (obs_p.size() !== 12) $display("FAIL early_p_count: got %0d expected 12", obs_p.size()); else passed++;
        checks++; if (obs_p.size() == 12 && obs_p[11] !== 8'd9) $display("FAIL early_last_p: got %0d expected 9", obs_p[11]); else passed++;
        checks++; if (jd_cyc !== 22) $display("FAIL early_jd_cyc: got %0d expected 22", jd_cyc); else passed++;
        checks++; if (jd_cnt !== 1) $display("FAIL early_jd_cnt: got %0d expected 1", jd_cnt); else passed++;
    endtask

    task automatic test_busy_ignore();
        logic [2:0][7:0] b;
        logic [7:0]      e;
        b = {8'd3, 8'd2, 8'd1};
        stage({8'd6, 8'd5, 8'd4}, {8'd11, 8'd10, 8'd9, 8'd8, 8'd7}, b);
        cfg_write(2'd1, 3'd6, 8'hAA);
        cfg_write(2'd2, 3'd3, 8'hBB);
        cfg_write(2'd3, 3'd0, 8'hCC);
        checks++; if (seq_err !== 1'b1) $display("FAIL ign_seq_err_sticky: got %b expected 1", seq_err); else passed++;
        run_job(1'b0, 12, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        checks++; if (seq_err_c1 !== 1'b0) $display("FAIL ign_seq_err_clr: got %b expected 0", seq_err_c1); else passed++;
        checks++; if (timed_out !== 1'b0) $display("FAIL ign_timeout: got %b expected 0", timed_out); else passed++;
        checks++; if (obs_fd.size() !== 3) $display("FAIL ign_f_count: got %0d expected 3", obs_fd.size()); else passed++;
        for (int k = 0; k < obs_fd.size() && k < 3; k++) begin
            checks++; if (obs_fd[k] !== 8'(k + 4)) $display("FAIL ign_f%0d: got %0d expected %0d", k, obs_fd[k], k + 4); else passed++;
        end
        for (int k = 0; k < obs_id.size() && k < 5; k++) begin
            checks++; if (obs_id[k] !== 8'(k + 7)) $display("FAIL ign_i%0d: got %0d expected %0d", k, obs_id[k], k + 7); else passed++;
        end
        checks++; if (jd_cnt !== 1 || jd_cyc !== 22) $display("FAIL ign_jd: got cnt %0d cyc %0d expected 1 22", jd_cnt, jd_cyc); else passed++;
        // Second job shows the buffers were not touched by the ignored writes.
        run_job(1'b0, 12, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        checks++; if (obs_id.size() !== 5) $display("FAIL ign2_i_count: got %0d expected 5", obs_id.size()); else passed++;
        for (int k = 0; k < obs_id.size() && k < 5; k++) begin
            checks++; if (obs_id[k] !== 8'(k + 7)) $display("FAIL ign2_i%0d: got %0d expected %0d", k, obs_id[k], k + 7); else passed++;
        end
        checks++; if (obs_p.size() !== 12) $display("FAIL ign2_p_count: got %0d expected 12", obs_p.size()); else passed++;
        for (int k = 0; k < obs_p.size() && k < 12; k++) begin
            e = ((k % 4) == 3) ? b[k / 4] : 8'd0;
            checks++; if (obs_p[k] !== e) $display("FAIL ign2_p%0d: got %0d expected %0d", k, obs_p[k], e); else passed++;
        end
    endtask

    task automatic test_mid_reset();
        stage({8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1});
        f_ready = 1'b1; i_ready = 1'b1; start_ready = 1'b1; p_ready = 1'b1;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (i_valid !== 1'b1 || i_addr !== 3'd1) $display("FAIL mrst_pre: got valid %b addr %0d expected 1 1", i_valid, i_addr); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (i_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mrst_async: got i_valid %b busy %b expected 0 0", i_valid, busy); else passed++;
        checks++; if (i_addr !== 3'd0 || i_data !== 8'd0) $display("FAIL mrst_i_out: got addr %0d data %0d expected 0 0", i_addr, i_data); else passed++;
        @(negedge clk);
        rst = 1'b0;
        run_job(1'b0, 12, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        checks++; if (obs_fc.size() !== 3 || obs_fc[0] !== 1) $display("FAIL mrst_restart_f: got count %0d expected 3 starting cycle 1", obs_fc.size()); else passed++;
        for (int k = 0; k < obs_fd.size() && k < 3; k++) begin
            checks++; if (obs_fd[k] !== 8'd0) $display("FAIL mrst_f%0d_cleared: got %0d expected 0", k, obs_fd[k]); else passed++;
        end
        checks++; if (start_cyc !== 9 || jd_cnt !== 1) $display("FAIL mrst_job: got start %0d jd %0d expected 9 1", start_cyc, jd_cnt); else passed++;
    endtask

`ifdef PE_LOADER_FILTER_SKIP_EN
    task automatic test_filter_skip();
        stage({8'd3, 8'd2, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd2, 8'd2, 8'd2});
        run_job(1'b0, 12, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        checks++; if (obs_fa.size() !== 3) $display("FAIL skip_first_f: got %0d expected 3", obs_fa.size()); else passed++;
        run_job(1'b0, 12, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        checks++; if (obs_fa.size() !== 0) $display("FAIL skip_no_f: got %0d expected 0", obs_fa.size()); else passed++;
        checks++; if (obs_ic.size() !== 5 || obs_ic[0] !== 1) $display("FAIL skip_i_first: got count %0d expected 5 from cycle 1", obs_ic.size()); else passed++;
        checks++; if (start_cyc !== 6) $display("FAIL skip_start_cyc: got %0d expected 6", start_cyc); else passed++;
        checks++; if (jd_cyc !== 19) $display("FAIL skip_jd_cyc: got %0d expected 19", jd_cyc); else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_sel = '0; cfg_wr_addr = '0; cfg_wr_data = '0;
        go = 1'b0;
        f_ready = 1'b0; i_ready = 1'b0; p_ready = 1'b0; start_ready = 1'b0; done_valid = 1'b0;
        test_reset();
        test_full_job();
        test_psum_stall();
        test_early_done();
        test_busy_ignore();
        test_mid_reset();
`ifdef PE_LOADER_FILTER_SKIP_EN
        test_filter_skip();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
